circle_buf_reader: RTL and testbench
====================================

# circle_buf_reader

Read-side drain sequencer for the double-buffered circular capture buffer. When a completed bank is available it issues exactly 2^aw read strobes and collects the returned samples. It emits them as a framed valid/ready stream: one header word carrying a frame count, then 2^aw samples. It sits on the buffer's read clock, between the buffer and the packetiser/DMA stage, and absorbs downstream backpressure with a small internal FIFO.

## Interface
- aw, 13: buffer bank address width; frame length is 2^aw samples.
- dw, 16: sample and output word width; must be ≥ 16.
- fifo_aw, 2: log2 of the output FIFO depth (depth 4).

- rclk  in  1  read-side clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 0 stops new frames from starting but never truncates a frame in progress.
- abort  in  1  pulse; discards the current frame and rewinds the bank.
- r_bank_available  in  1  a full bank is ready to read.
- stb_r  out  1  read strobe to the buffer; one sample per strobe.
- rewind  out  1  one-cycle pulse; resets the buffer read address without swapping banks.
- data_r  in  dw  sample returned by the buffer.
- data_gate_out  in  1  data_r is valid; arrives 1 cycle after stb_r.
- dout  out  dw  output word.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  downstream accepts dout.
- dout_first  out  1  marks the header word.
- dout_last  out  1  marks the final sample of a frame.
- frame_count  out  16  number of frames completed.
- busy  out  1  state ≠ IDLE, or FIFO not empty.

## Operation
- State machine states: IDLE, HEADER, READ, FLUSH, ABORT.
- IDLE → HEADER when enable & r_bank_available & FIFO has a free entry.
- HEADER:
  - Pushes one word into the FIFO: {dw-16 zeros, frame_count}, tagged first.
  - Goes to READ on the next cycle.
- READ:
  - stb_r = 1 when (FIFO occupancy + in-flight strobes) < depth.
  - At most one strobe is in flight, because returns come one cycle later.
  - Strobe counter sc (aw+1 bits) counts strobes.
  - After strobe number 2^aw is issued, go to FLUSH. That strobe is the one that makes the buffer swap banks.
- Return path:
  - Each data_gate_out pushes data_r into the FIFO.
  - The return matching the final strobe is tagged last.
  - data_gate_out arriving in IDLE is ignored and never enters the FIFO.
- FLUSH:
  - Waits one cycle for the last return.
  - Increments frame_count (16-bit, wraps 0xFFFF → 0).
  - Goes to IDLE.
  - IDLE ignores r_bank_available during the first cycle after FLUSH, so the stale pre-swap level cannot start a frame.
- FIFO: first-word-fall-through. dout/dout_first/dout_last come from its head; dout_valid = not empty; pop on dout_valid & dout_ready.
- abort, any state except IDLE:
  - Go to ABORT, stop strobes, flush the FIFO and the in-flight return.
  - Pulse rewind for 1 cycle, return to IDLE.
  - frame_count is unchanged; the same bank is re-read as a fresh frame with the same count.
  - abort in IDLE has no effect.
  - abort coinciding with the final strobe: the strobe still issues and the bank has swapped, so treat it as completion and enter FLUSH, not ABORT.
- enable deasserted mid-frame: the frame completes normally; only new starts are blocked.

## Timing
- Reset values: stb_r=0, rewind=0, dout_valid=0, dout_first=0, dout_last=0, dout=0, frame_count=0, busy=0, state IDLE, FIFO empty.
- Latency:
  - r_bank_available rise → header on dout: 2 cycles (IDLE decision, HEADER push, FIFO fall-through).
  - First stb_r one cycle after HEADER.
- With dout_ready held high, frame output is 1 + 2^aw consecutive words, gap-free after the first sample.
- Backpressure:
  - dout_valid held with dout stable until accepted.
  - No FIFO overflow ever; a push into a full FIFO is a verification failure.
- stb_r never exceeds 2^aw per frame. rewind is never asserted on the same cycle as stb_r.

## Structure
- Shared package:
  - State enum.
  - Header layout constant (frame count in bits [15:0]).
  - Tag bit positions (first/last) for FIFO entries.
- One sub-module, circle_buf_reader_fifo: sync FWFT FIFO, width dw+2, depth 2^fifo_aw, with occupancy output and a synchronous flush input.

## Test plan
- aw=3, dout_ready=1, pulse r_bank_available → header 0x0000 with first, then 8 samples in order, last on the 8th; exactly 8 stb_r; frame_count=1.
- dout_ready random 50%, 3 back-to-back frames → 27 words, headers 0,1,2, no loss or duplication, never more than 4 words buffered.
- abort after 4 strobes → one rewind pulse, FIFO emptied, frame_count stays 0; re-read frame is header 0 plus 8 samples.
- abort on the 8th strobe cycle → no rewind, frame completes, frame_count=1.
- enable=0 mid-frame → frame completes; r_bank_available high afterwards starts nothing until enable=1.
- reset_n asserted mid-frame → all outputs return to reset values asynchronously; after release, header count restarts at 0.

Source files
------------

// File: rtl/circle_buf_reader_pkg.sv
// circle_buf_reader_pkg: state encoding, header layout and FIFO entry tag positions
package circle_buf_reader_pkg;
  typedef enum logic [2:0] {st_idle, st_header, st_read, st_flush, st_abort} state_t;
  localparam int hdr_cnt_lsb = 0;
  localparam int hdr_cnt_w = 16;
  localparam int tag_first = 0;
  localparam int tag_last = 1;
  localparam int tag_w = 2;
endpackage

// File: rtl/circle_buf_reader_fifo.sv
// circle_buf_reader_fifo: first-word-fall-through FIFO with occupancy output and synchronous flush
module circle_buf_reader_fifo #(
  parameter int w = 18,
  parameter int aw = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [w-1:0] i_din,
  input  logic         i_pop,
  output logic [w-1:0] o_head,
  output logic         o_empty,
  output logic         o_full,
  output logic [aw:0]  o_occ
);
  logic [w-1:0] r_mem [2**aw];
  logic [aw-1:0] r_wp, r_rp;
  logic [aw:0] r_occ;
  logic w_push, w_pop;
  assign o_empty = r_occ == '0;
  assign o_full = r_occ == (aw+1)'(2**aw);
  assign o_occ = r_occ;
  assign o_head = r_mem[r_rp];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp] <= i_din;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_occ <= '0;
    end else if (i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
      r_occ <= '0;
    end else begin
      r_wp <= r_wp + aw'(w_push);
      r_rp <= r_rp + aw'(w_pop);
      r_occ <= r_occ + (aw+1)'(w_push) - (aw+1)'(w_pop);
    end
endmodule

// File: rtl/circle_buf_reader.sv
// circle_buf_reader: drains a completed capture bank as a framed stream (header word + 2^aw samples)
module circle_buf_reader
  import circle_buf_reader_pkg::*;
#(
  parameter int aw = 13,
  parameter int dw = 16,
  parameter int fifo_aw = 2
) (
  input  logic          rclk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          abort,
  input  logic          r_bank_available,
  output logic          stb_r,
  output logic          rewind,
  input  logic [dw-1:0] data_r,
  input  logic          data_gate_out,
  output logic [dw-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_first,
  output logic          dout_last,
  output logic [15:0]   frame_count,
  output logic          busy
);
  localparam logic [aw:0] last_sc = (aw+1)'((1 << aw) - 1);
  localparam logic [fifo_aw+1:0] depth = (fifo_aw+2)'(1 << fifo_aw);
  state_t r_state;
  logic [aw:0] r_sc;
  logic r_inflight, r_last_inflight, r_post_flush;
  logic [hdr_cnt_w-1:0] r_frame_count;
  logic w_final, w_hdr, w_abort_go, w_push, w_pop, w_flush, w_empty, w_full;
  logic [fifo_aw:0] w_occ;
  logic [dw+tag_w-1:0] w_din, w_head;
  // one strobe may be in flight, so reserve its slot before issuing another
  assign stb_r = (r_state == st_read) && ((fifo_aw+2)'(w_occ) + (fifo_aw+2)'(r_inflight) < depth);
  assign w_final = stb_r && (r_sc == last_sc);
  assign w_hdr = r_state == st_header;
  // once the final strobe has gone out the bank has swapped, so abort can no longer rewind it
  assign w_abort_go = abort && (w_hdr || (r_state == st_read && !w_final));
  assign w_push = w_hdr || (data_gate_out && (r_state == st_read || r_state == st_flush));
  assign w_flush = w_abort_go || r_state == st_abort;
  assign w_pop = dout_valid && dout_ready;
  always_comb begin
    w_din = '0;
    w_din[dw-1:0] = w_hdr ? dw'(r_frame_count) << hdr_cnt_lsb : data_r;
    w_din[dw+tag_first] = w_hdr;
    w_din[dw+tag_last] = !w_hdr && r_last_inflight;
  end
  circle_buf_reader_fifo #(.w(dw+tag_w), .aw(fifo_aw)) u_fifo (
    .i_clk(rclk),
    .i_rst_n(reset_n),
    .i_flush(w_flush),
    .i_push(w_push),
    .i_din(w_din),
    .i_pop(w_pop),
    .o_head(w_head),
    .o_empty(w_empty),
    .o_full(w_full),
    .o_occ(w_occ)
  );
  assign dout_valid = !w_empty;
  assign dout = w_empty ? '0 : w_head[dw-1:0];
  assign dout_first = !w_empty && w_head[dw+tag_first];
  assign dout_last = !w_empty && w_head[dw+tag_last];
  assign rewind = r_state == st_abort;
  assign busy = r_state != st_idle || !w_empty;
  assign frame_count = r_frame_count;
  always_ff @(posedge rclk or negedge reset_n)
    if (!reset_n) begin
      r_state <= st_idle;
      r_sc <= '0;
      r_inflight <= 1'b0;
      r_last_inflight <= 1'b0;
      r_post_flush <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_inflight <= stb_r;
      r_last_inflight <= w_final;
      r_post_flush <= r_state == st_flush;
      if (stb_r) r_sc <= r_sc + 1'b1;
      case (r_state)
        st_idle:
          if (enable && r_bank_available && !w_full && !r_post_flush) begin
            r_state <= st_header;
            r_sc <= '0;
          end
        st_header: r_state <= w_abort_go ? st_abort : st_read;
        st_read: r_state <= w_final ? st_flush : w_abort_go ? st_abort : st_read;
        st_flush: begin
          r_state <= st_idle;
          r_frame_count <= r_frame_count + 1'b1;
        end
        default: r_state <= st_idle;
      endcase
    end
endmodule

// File: tb/tb_circle_buf_reader.sv
// tb_circle_buf_reader: directed scoreboard bench with a behavioural double-bank buffer model
module tb_circle_buf_reader;
  logic rclk = 1'b0;
  logic reset_n, enable, abort, r_bank_available, dout_ready, data_gate_out;
  logic stb_r, rewind, dout_valid, dout_first, dout_last, busy;
  logic [15:0] data_r, dout, frame_count;
  int total = 0, bad = 0;
  logic [17:0] exp_q [$];
  int stb_total = 0, rew_total = 0, acc_total = 0, acc_samp = 0, addr = 0;
  int max_buf = 0, s_win = 0, a_win = 0;
  logic [7:0] bank = 8'd0;
  logic pend = 1'b0, hold_chk = 1'b0, track = 1'b0, rand_ready = 1'b0;
  logic [15:0] pend_d = 16'd0, hold_d = 16'd0, exp_fc = 16'd0;
  logic [7:0] exp_bank = 8'd0;
  int base, r0, s1, acc0, n;

  circle_buf_reader #(.aw(3), .dw(16), .fifo_aw(2)) dut (
    .rclk(rclk), .reset_n(reset_n), .enable(enable), .abort(abort),
    .r_bank_available(r_bank_available), .stb_r(stb_r), .rewind(rewind),
    .data_r(data_r), .data_gate_out(data_gate_out), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_first(dout_first),
    .dout_last(dout_last), .frame_count(frame_count), .busy(busy)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // negedge: buffer model (returns one cycle after each strobe) and output monitor
  task automatic sample();
    logic [17:0] e;
    int b;
    if (!reset_n) begin
      addr = 0;
      pend = 1'b0;
      hold_chk = 1'b0;
    end
    data_gate_out = pend;
    data_r = pend_d;
    pend = stb_r;
    if (stb_r) begin
      pend_d = {bank, 8'(addr)};
      addr++;
      stb_total++;
      if (addr == 8) begin
        addr = 0;
        bank++;
      end
    end
    if (rewind) begin
      rew_total++;
      chk("rewind_vs_stb", 32'(stb_r), 0);
      addr = 0;
    end
    if (hold_chk) chk("hold", {dout_valid, dout}, {1'b1, hold_d});
    hold_chk = dout_valid && !dout_ready;
    hold_d = dout;
    if (dout_valid && dout_ready) begin
      acc_total++;
      if (!dout_first) acc_samp++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL extra_word got=%0h exp=none", {dout_first, dout_last, dout});
      end else begin
        e = exp_q.pop_front();
        chk("word", 32'({dout_first, dout_last, dout}), 32'(e));
      end
    end
    if (track) begin
      b = (stb_total - s_win) - (acc_samp - a_win);
      if (b > max_buf) max_buf = b;
    end
  endtask

  task automatic tick();
    @(negedge rclk);
    sample();
    @(posedge rclk);
    #1;
    if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_frame(input logic [15:0] fc, input logic [7:0] bk);
    exp_q.push_back({2'b10, fc});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, i == 7, bk, 8'(i)});
  endtask

  task automatic start_frame();
    int s = stb_total;
    int k = 0;
    r_bank_available = 1'b1;
    while (stb_total == s && k < 500) begin
      tick();
      k++;
    end
    r_bank_available = 1'b0;
    chk("start_timeout", 32'(k < 500), 1);
  endtask

  task automatic wait_strobes(input int b0);
    int k = 0;
    while (stb_total - b0 < 8 && k < 2000) begin
      tick();
      k++;
    end
    chk("strobe_timeout", 32'(k < 2000), 1);
  endtask

  task automatic wait_done(input int b0);
    int k = 0;
    while ((stb_total - b0 < 8 || busy || exp_q.size() != 0) && k < 3000) begin
      tick();
      k++;
    end
    chk("drain_timeout", 32'(k < 3000), 1);
    chk("stb_per_frame", stb_total - b0, 8);
  endtask

  task automatic check_reset();
    chk("rst_stb", 32'(stb_r), 0);
    chk("rst_rewind", 32'(rewind), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_first", 32'(dout_first), 0);
    chk("rst_last", 32'(dout_last), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_fc", 32'(frame_count), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    abort = 1'b0;
    r_bank_available = 1'b0;
    dout_ready = 1'b1;
    data_gate_out = 1'b0;
    data_r = 16'd0;
    #1;
    tick();
    tick();
    check_reset();
    reset_n = 1'b1;
    tick();
    // single frame, header latency and first strobe
    enable = 1'b1;
    push_frame(exp_fc, exp_bank);
    base = stb_total;
    r_bank_available = 1'b1;
    tick();
    r_bank_available = 1'b0;
    chk("hdr_lat_1", 32'(dout_valid), 0);
    tick();
    chk("hdr_lat_2", 32'(dout_valid), 1);
    chk("hdr_first", 32'(dout_first), 1);
    chk("hdr_word", 32'(dout), 0);
    chk("first_stb", 32'(stb_r), 1);
    wait_done(base);
    exp_fc++;
    exp_bank++;
    chk("fc_single", 32'(frame_count), 32'(exp_fc));
    // three frames under random backpressure
    rand_ready = 1'b1;
    s_win = stb_total;
    a_win = acc_samp;
    acc0 = acc_total;
    max_buf = 0;
    track = 1'b1;
    for (int f = 0; f < 3; f++) begin
      push_frame(exp_fc, exp_bank);
      base = stb_total;
      start_frame();
      wait_strobes(base);
      exp_fc++;
      exp_bank++;
    end
    wait_done(base);
    track = 1'b0;
    rand_ready = 1'b0;
    dout_ready = 1'b1;
    chk("bp_words", acc_total - acc0, 27);
    chk("bp_max_buffered", 32'(max_buf <= 4), 1);
    chk("fc_bp", 32'(frame_count), 32'(exp_fc));
    // abort mid-frame, then re-read the same bank
    push_frame(exp_fc, exp_bank);
    base = stb_total;
    r0 = rew_total;
    start_frame();
    n = 0;
    while (stb_total - base < 4 && n < 100) begin
      tick();
      n++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_rewind", 32'(rewind), 1);
    chk("abort_no_stb", 32'(stb_r), 0);
    exp_q.delete();
    tick();
    chk("abort_rewind_end", 32'(rewind), 0);
    chk("abort_emptied", 32'(busy), 0);
    chk("abort_fc", 32'(frame_count), 32'(exp_fc));
    push_frame(exp_fc, exp_bank);
    base = stb_total;
    start_frame();
    wait_done(base);
    exp_fc++;
    exp_bank++;
    chk("abort_rewinds", rew_total - r0, 1);
    chk("fc_reread", 32'(frame_count), 32'(exp_fc));
    // abort coinciding with the final strobe completes the frame
    push_frame(exp_fc, exp_bank);
    base = stb_total;
    r0 = rew_total;
    start_frame();
    n = 0;
    while (!(stb_r && stb_total - base == 7) && n < 100) begin
      tick();
      n++;
    end
    chk("final_stb_seen", 32'(n < 100), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("final_abort_rewind", 32'(rewind), 0);
    tick();
    chk("final_abort_rewind2", 32'(rewind), 0);
    wait_done(base);
    exp_fc++;
    exp_bank++;
    chk("final_abort_rewinds", rew_total - r0, 0);
    chk("fc_final_abort", 32'(frame_count), 32'(exp_fc));
    // enable dropped mid-frame
    push_frame(exp_fc, exp_bank);
    base = stb_total;
    start_frame();
    tick();
    tick();
    enable = 1'b0;
    wait_done(base);
    exp_fc++;
    exp_bank++;
    chk("fc_enable_off", 32'(frame_count), 32'(exp_fc));
    s1 = stb_total;
    r_bank_available = 1'b1;
    repeat (20) tick();
    chk("enable_blocks_stb", stb_total - s1, 0);
    chk("enable_blocks_busy", 32'(busy), 0);
    push_frame(exp_fc, exp_bank);
    base = stb_total;
    enable = 1'b1;
    start_frame();
    wait_done(base);
    exp_fc++;
    exp_bank++;
    chk("fc_enable_on", 32'(frame_count), 32'(exp_fc));
    // asynchronous reset mid-frame
    push_frame(exp_fc, exp_bank);
    base = stb_total;
    start_frame();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset();
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    exp_fc = 16'd0;
    push_frame(exp_fc, exp_bank);
    base = stb_total;
    start_frame();
    wait_done(base);
    chk("fc_after_reset", 32'(frame_count), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
